// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of encrypted stores drained to data memory, with flush and optional load forwarding.
// Optional feature macro: STORE_BUFFER_FWD_EN enables load-to-store forwarding (ld_hit/ld_data).
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     mem_req,
  input  logic                     mem_ack,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic          pend;
  logic          push;
  logic          pop;
  logic          done_now;
  logic [CW-1:0] count_nxt;

  // Readiness comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign st_ready = (count != CW'(DEPTH)) && !pend;
  assign push     = st_valid && st_ready;
  assign pop      = (state == REQ) && mem_ack;
  assign done_now = (pend || flush) && (count == '0) && (state == IDLE) && !push;

  assign mem_req   = (state == REQ);
  assign mem_addr  = mem_req ? addr_q[head] : '0;
  assign mem_wdata = mem_req ? data_q[head] : '0;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Drain FSM: request while entries remain, return to IDLE when the last one is acknowledged.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = REQ;
      REQ:     if (pop && (count_nxt == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      state      <= IDLE;
      pend       <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      if (push) begin
        addr_q[tail] <= st_addr;
        data_q[tail] <= st_data;
        tail         <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count      <= count_nxt;
      state      <= state_nxt;
      flush_done <= done_now;
      pend       <= done_now ? 1'b0 : (pend || flush);
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] idx;
  logic          unused_ld;
  assign unused_ld = ^ld_addr[1:0];

  // Walk oldest to youngest so the last match (youngest) wins; popping entry is still counted.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx][AW-1:2] == ld_addr[AW-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end
`else
  logic unused_ld;
  assign unused_ld = ^ld_addr;
  assign ld_hit    = 1'b0;
  assign ld_data   = '0;
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of entries; SHALL be a power of two, at least 2.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 st_valid  input  1  processor presents a store (address plus encrypted data from the security stage).
REQ-007 st_ready  output  1  buffer can accept a store this cycle.
REQ-008 st_addr  input  AW  store byte address.
REQ-009 st_data  input  DW  encrypted store data (data_out_mem).
REQ-010 mem_req  output  1  write request to data memory.
REQ-011 mem_ack  input  1  memory accepted the current write.
REQ-012 mem_addr  output  AW  write address; valid while mem_req=1.
REQ-013 mem_wdata  output  DW  write data; valid while mem_req=1.
REQ-014 ld_addr  input  AW  load lookup address.
REQ-015 ld_hit  output  1  ld_addr matches a buffered store.
REQ-016 ld_data  output  DW  forwarded data from the youngest matching entry.
REQ-017 flush  input  1  single-cycle request to drain all entries.
REQ-018 flush_done  output  1  one-cycle pulse when a requested drain completes.
REQ-019 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-020 Storage SHALL be a circular FIFO: head and tail pointers wrap modulo DEPTH; count is registered.
REQ-021 st_ready SHALL be 1 exactly when count<DEPTH and no flush is pending; it depends on registered state only.
REQ-022 A push (st_valid & st_ready) SHALL write {st_addr,st_data} at tail and advance tail.
REQ-023 When full, st_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-024 The FSM SHALL have two states: IDLE (mem_req=0) and REQ (mem_req=1).
REQ-025 IDLE->REQ when count>0; an entry pushed at edge N SHALL produce mem_req=1 after edge N+1.
REQ-026 In REQ, mem_addr/mem_wdata SHALL present the head entry and stay stable until mem_ack.
REQ-027 In REQ with mem_ack=1: pop head; remain in REQ if the post-pop count is >0, else go to IDLE.
REQ-028 mem_ack SHALL be ignored in IDLE.
REQ-029 A simultaneous push and pop SHALL leave count unchanged.
REQ-030 count SHALL never exceed DEPTH or underflow 0.
REQ-031 flush SHALL set a pending flag. While pending, pushes are blocked and draining continues.
REQ-032 When a flush is pending, count==0 and the FSM is in IDLE, flush_done SHALL pulse for one cycle and clear the pending flag.
REQ-033 A flush asserted while the buffer is already empty and idle SHALL produce flush_done on the following cycle.
REQ-034 Forwarding: ld_hit/ld_data are combinational. The compare uses address bits [AW-1:2] across occupied entries only; the youngest match wins.
REQ-035 The entry being popped in the current cycle SHALL still be eligible for forwarding that cycle.

Reset
REQ-036 On reset: head=tail=0, count=0, state=IDLE, flush pending cleared. Reset values: mem_req=0, flush_done=0, st_ready=1, mem_addr=0, mem_wdata=0, ld_hit=0, ld_data=0.
REQ-037 Reset during REQ SHALL drop mem_req the next cycle and discard all entries.
REQ-038 Reset SHALL take priority over push, pop and flush in the same cycle.

Configuration
REQ-039 Macro STORE_BUFFER_FWD_EN defined: forwarding per REQ-034/035 is compiled in.
REQ-040 STORE_BUFFER_FWD_EN undefined: no compare logic; ld_hit and ld_data are tied to constant 0.

Verification
REQ-041 Push (0x100,0xDEADBEEF) at edge 0, mem_ack tied 1 -> mem_req=1 with mem_addr=0x100, mem_wdata=0xDEADBEEF after edge 1; count returns to 0 after edge 2.
REQ-042 mem_ack=0, push 4 stores -> count=4, st_ready=0; a 5th st_valid is not accepted; mem_addr holds the first address.
REQ-043 Full buffer with st_valid=1 and mem_ack=1 -> pop only (count 4->3); the push is accepted on the next cycle (count stays 3).
REQ-044 Push (0x200,A) then (0x200,B), mem_ack=0, ld_addr=0x202 -> ld_hit=1, ld_data=B with macro defined; ld_hit=0 without it.
REQ-045 3 entries, flush pulse, mem_ack=1 -> st_ready=0 until flush_done; flush_done pulses exactly once, the cycle after count reaches 0.
REQ-046 reset asserted while mem_req=1 with count=2 -> mem_req=0 and count=0 after the reset edge; mem_ack is ignored afterwards.
